// File: rtl/nuevo_design_pio_pkg.sv
// Shared definitions for the Nios II bus PIO slaves: register offsets,
// edge-type encodings and a constant-width helper.
package nuevo_design_pio_pkg;

   typedef enum logic [1:0] {
      PIO_DATA    = 2'd0,
      PIO_RSVD    = 2'd1,
      PIO_IRQMASK = 2'd2,
      PIO_EDGECAP = 2'd3
   } pio_reg_e;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   function automatic int pio_clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result++;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/pio_debounce.sv
// One input bit: two-flop synchronizer followed by a persistence filter that
// only accepts a new level after it has held for DEBOUNCE_CYCLES clocks.
module pio_debounce
   import nuevo_design_pio_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic RESET_BIT       = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic level
);

   localparam int CW = (pio_clog2(DEBOUNCE_CYCLES) < 1) ? 1 : pio_clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] count;

   // Any return to the accepted level restarts the count, so bounces never accumulate.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= RESET_BIT;
         sync2 <= RESET_BIT;
         level <= RESET_BIT;
         count <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == level) begin
            count <= '0;
         end else if (count == CNT_MAX) begin
            level <= sync2;
            count <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/nuevo_design_key_pio_in.sv
// Avalon-MM input PIO for push-buttons/switches: debounced level, edge capture
// with write-1-to-clear, interrupt mask and a level-sensitive irq.
module nuevo_design_key_pio_in
   import nuevo_design_pio_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter int               EDGE_TYPE       = EDGE_FALLING,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] ec_clear;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic             wr_en;
   pio_reg_e         reg_sel;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      pio_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RESET_BIT      (RESET_VALUE[i])
      ) u_debounce (
         .clk    (clk),
         .reset_n(reset_n),
         .raw    (in_port[i]),
         .level  (stable[i])
      );
   end

   assign reg_sel      = pio_reg_e'(address);
   assign wr_en        = chipselect && !write_n;
   assign ec_clear     = (wr_en && reg_sel == PIO_EDGECAP) ? writedata[WIDTH-1:0] : '0;
   assign unused_wdata = ^writedata;

   always_comb begin
      case (EDGE_TYPE)
         EDGE_RISING:  edge_det = stable & ~stable_d;
         EDGE_FALLING: edge_det = ~stable & stable_d;
         default:      edge_det = stable ^ stable_d;
      endcase
   end

   // A new edge is OR'd in after the clear, so a same-cycle set survives the write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_d     <= RESET_VALUE;
         irq_mask     <= '0;
         edge_capture <= '0;
      end else begin
         stable_d <= stable;
         if (wr_en && reg_sel == PIO_IRQMASK) begin
            irq_mask <= writedata[WIDTH-1:0];
         end
         edge_capture <= (edge_capture & ~ec_clear) | edge_det;
      end
   end

   always_comb begin
      readdata = '0;
      case (reg_sel)
         PIO_DATA:    readdata[WIDTH-1:0] = stable;
         PIO_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
         PIO_EDGECAP: readdata[WIDTH-1:0] = edge_capture;
         default:     readdata = '0;
      endcase
   end

   assign irq = |(edge_capture & irq_mask);

endmodule
